// File: rtl/dca_mlsu_inst_arbiter_pkg.sv
// Shared types and helpers for the MLSU instruction arbiter: FSM state encoding and owner-index width.
package dca_mlsu_inst_arbiter_pkg;

  localparam int DCA_MATRIX_LSU_INST_BW = 32;
  localparam int DCA_TENSOR_ROW_BW      = 128;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RUN   = 2'd2
  } arb_state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int owner_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dca_rr_pick.sv
// Combinational round-robin picker: first asserted request searching from ptr+1 with modulo wrap.
module dca_rr_pick
  import dca_mlsu_inst_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int BW_OWNER = owner_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [BW_OWNER-1:0] ptr,
  output logic                valid,
  output logic [BW_OWNER-1:0] idx
);

  // Distance of requester i after ptr: ptr+1 is 0, ptr itself is NUM_REQ-1.
  function automatic int dist_from_ptr(input int i, input int p);
    return (i + 2 * NUM_REQ - 1 - p) % NUM_REQ;
  endfunction

  int best_dist;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    valid     = 1'b0;
    idx       = '0;
    best_dist = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (dist_from_ptr(i, int'(ptr)) < best_dist)) begin
        best_dist = dist_from_ptr(i, int'(ptr));
        valid     = 1'b1;
        idx       = BW_OWNER'(i);
      end
    end
  end

endmodule

// File: rtl/dca_mlsu_inst_arbiter.sv
// Shares one matrix LSU between NUM_REQ requesters: round-robin instruction grant held until execute_finish.
module dca_mlsu_inst_arbiter
  import dca_mlsu_inst_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int BW_INST = DCA_MATRIX_LSU_INST_BW,
  parameter int BW_ROW  = DCA_TENSOR_ROW_BW
) (
  input  logic                       clk,
  input  logic                       rstp,
  // requester side
  input  logic [NUM_REQ-1:0]         r_sinst_wvalid,
  input  logic [NUM_REQ*BW_INST-1:0] r_sinst_wdata,
  output logic [NUM_REQ-1:0]         r_sinst_wready,
  output logic [NUM_REQ-1:0]         r_sinst_decode_finish,
  output logic [NUM_REQ-1:0]         r_sinst_execute_finish,
  output logic [NUM_REQ-1:0]         r_sinst_busy,
  output logic [NUM_REQ-1:0]         r_sload_tensor_row_wvalid,
  output logic [NUM_REQ-1:0]         r_sload_tensor_row_wlast,
  output logic [BW_ROW-1:0]          r_sload_tensor_row_wdata,
  input  logic [NUM_REQ-1:0]         r_sload_tensor_row_wready,
  output logic [NUM_REQ-1:0]         r_sstore_tensor_row_rvalid,
  output logic [NUM_REQ-1:0]         r_sstore_tensor_row_rlast,
  input  logic [NUM_REQ-1:0]         r_sstore_tensor_row_rready,
  input  logic [NUM_REQ*BW_ROW-1:0]  r_sstore_tensor_row_rdata,
  // MLSU side
  output logic                       m_sinst_wvalid,
  output logic [BW_INST-1:0]         m_sinst_wdata,
  input  logic                       m_sinst_wready,
  input  logic                       m_sinst_decode_finish,
  input  logic                       m_sinst_execute_finish,
  input  logic                       m_sinst_busy,
  input  logic                       m_sload_tensor_row_wvalid,
  input  logic                       m_sload_tensor_row_wlast,
  input  logic [BW_ROW-1:0]          m_sload_tensor_row_wdata,
  output logic                       m_sload_tensor_row_wready,
  input  logic                       m_sstore_tensor_row_rvalid,
  input  logic                       m_sstore_tensor_row_rlast,
  output logic                       m_sstore_tensor_row_rready,
  output logic [BW_ROW-1:0]          m_sstore_tensor_row_rdata,
  // status
  output logic [NUM_REQ-1:0]         grant_onehot,
  output logic                       arb_busy
);

  localparam int BW_OWNER = owner_bits(NUM_REQ);

  arb_state_t          state, state_n;
  logic [BW_OWNER-1:0] owner, owner_n;
  logic [BW_OWNER-1:0] rr_ptr, rr_ptr_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic                err_orphan, err_orphan_n;
  logic                pick_valid;
  logic [BW_OWNER-1:0] pick_idx;

  logic [BW_INST-1:0]  inst_arr [NUM_REQ];
  logic [BW_ROW-1:0]   srow_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign inst_arr[g] = r_sinst_wdata[g*BW_INST +: BW_INST];
    assign srow_arr[g] = r_sstore_tensor_row_rdata[g*BW_ROW +: BW_ROW];
  end

  dca_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .BW_OWNER (BW_OWNER)
  ) u_pick (
    .req   (r_sinst_wvalid),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rstp) begin
      state        <= ARB_IDLE;
      owner        <= '0;
      rr_ptr       <= BW_OWNER'(NUM_REQ - 1);
      grant_onehot <= '0;
      err_orphan   <= 1'b0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      rr_ptr       <= rr_ptr_n;
      grant_onehot <= grant_n;
      err_orphan   <= err_orphan_n;
    end
  end

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    rr_ptr_n     = rr_ptr;
    grant_n      = grant_onehot;
    err_orphan_n = err_orphan;
    unique case (state)
      ARB_IDLE: begin
        // Nobody owns the MLSU, so any completion pulse here has no destination.
        err_orphan_n = err_orphan | m_sinst_decode_finish | m_sinst_execute_finish;
        if (pick_valid) begin
          owner_n           = pick_idx;
          grant_n           = '0;
          grant_n[pick_idx] = 1'b1;
          state_n           = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (r_sinst_wvalid[owner] && m_sinst_wready) begin
          rr_ptr_n = owner;
          if (m_sinst_execute_finish) begin
            state_n = ARB_IDLE;
            grant_n = '0;
          end else begin
            state_n = ARB_RUN;
          end
        end
      end
      ARB_RUN: begin
        if (m_sinst_execute_finish) begin
          state_n = ARB_IDLE;
          grant_n = '0;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_comb begin
    m_sinst_wvalid             = 1'b0;
    m_sinst_wdata              = '0;
    r_sinst_wready             = '0;
    r_sinst_decode_finish      = '0;
    r_sinst_execute_finish     = '0;
    r_sinst_busy               = '0;
    r_sload_tensor_row_wvalid  = '0;
    r_sload_tensor_row_wlast   = '0;
    r_sload_tensor_row_wdata   = '0;
    m_sload_tensor_row_wready  = 1'b0;
    r_sstore_tensor_row_rvalid = '0;
    r_sstore_tensor_row_rlast  = '0;
    m_sstore_tensor_row_rready = 1'b0;
    m_sstore_tensor_row_rdata  = '0;

    if (state == ARB_ISSUE) begin
      m_sinst_wvalid        = r_sinst_wvalid[owner];
      m_sinst_wdata         = inst_arr[owner];
      r_sinst_wready[owner] = m_sinst_wready;
    end

    // Pulses reach the owner in ISSUE as well, covering finish coincident with the handshake.
    if (state != ARB_IDLE) begin
      r_sinst_decode_finish[owner]  = m_sinst_decode_finish;
      r_sinst_execute_finish[owner] = m_sinst_execute_finish;
    end

    if (state == ARB_RUN) begin
      r_sinst_busy[owner]               = m_sinst_busy;
      r_sload_tensor_row_wvalid[owner]  = m_sload_tensor_row_wvalid;
      r_sload_tensor_row_wlast[owner]   = m_sload_tensor_row_wlast;
      r_sload_tensor_row_wdata          = m_sload_tensor_row_wdata;
      m_sload_tensor_row_wready         = r_sload_tensor_row_wready[owner];
      r_sstore_tensor_row_rvalid[owner] = m_sstore_tensor_row_rvalid;
      r_sstore_tensor_row_rlast[owner]  = m_sstore_tensor_row_rlast;
      m_sstore_tensor_row_rready        = r_sstore_tensor_row_rready[owner];
      m_sstore_tensor_row_rdata         = srow_arr[owner];
    end
  end

  assign arb_busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_dca_mlsu_inst_arbiter.sv
// Self-checking bench for dca_mlsu_inst_arbiter: vector table, directed corner sequences, random vs. reference model.
module tb_dca_mlsu_inst_arbiter;

  localparam int N       = 3;
  localparam int BW_INST = 32;
  localparam int BW_ROW  = 128;

  logic                  clk = 1'b0;
  logic                  rstp;
  logic [N-1:0]          r_sinst_wvalid;
  logic [N*BW_INST-1:0]  r_sinst_wdata;
  logic [N-1:0]          r_sinst_wready;
  logic [N-1:0]          r_sinst_decode_finish;
  logic [N-1:0]          r_sinst_execute_finish;
  logic [N-1:0]          r_sinst_busy;
  logic [N-1:0]          r_sload_tensor_row_wvalid;
  logic [N-1:0]          r_sload_tensor_row_wlast;
  logic [BW_ROW-1:0]     r_sload_tensor_row_wdata;
  logic [N-1:0]          r_sload_tensor_row_wready;
  logic [N-1:0]          r_sstore_tensor_row_rvalid;
  logic [N-1:0]          r_sstore_tensor_row_rlast;
  logic [N-1:0]          r_sstore_tensor_row_rready;
  logic [N*BW_ROW-1:0]   r_sstore_tensor_row_rdata;
  logic                  m_sinst_wvalid;
  logic [BW_INST-1:0]    m_sinst_wdata;
  logic                  m_sinst_wready;
  logic                  m_sinst_decode_finish;
  logic                  m_sinst_execute_finish;
  logic                  m_sinst_busy;
  logic                  m_sload_tensor_row_wvalid;
  logic                  m_sload_tensor_row_wlast;
  logic [BW_ROW-1:0]     m_sload_tensor_row_wdata;
  logic                  m_sload_tensor_row_wready;
  logic                  m_sstore_tensor_row_rvalid;
  logic                  m_sstore_tensor_row_rlast;
  logic                  m_sstore_tensor_row_rready;
  logic [BW_ROW-1:0]     m_sstore_tensor_row_rdata;
  logic [N-1:0]          grant_onehot;
  logic                  arb_busy;

  always #5 clk = ~clk;

  dca_mlsu_inst_arbiter #(.NUM_REQ(N), .BW_INST(BW_INST), .BW_ROW(BW_ROW)) dut (
    .clk(clk), .rstp(rstp),
    .r_sinst_wvalid(r_sinst_wvalid), .r_sinst_wdata(r_sinst_wdata), .r_sinst_wready(r_sinst_wready),
    .r_sinst_decode_finish(r_sinst_decode_finish), .r_sinst_execute_finish(r_sinst_execute_finish),
    .r_sinst_busy(r_sinst_busy),
    .r_sload_tensor_row_wvalid(r_sload_tensor_row_wvalid), .r_sload_tensor_row_wlast(r_sload_tensor_row_wlast),
    .r_sload_tensor_row_wdata(r_sload_tensor_row_wdata), .r_sload_tensor_row_wready(r_sload_tensor_row_wready),
    .r_sstore_tensor_row_rvalid(r_sstore_tensor_row_rvalid), .r_sstore_tensor_row_rlast(r_sstore_tensor_row_rlast),
    .r_sstore_tensor_row_rready(r_sstore_tensor_row_rready), .r_sstore_tensor_row_rdata(r_sstore_tensor_row_rdata),
    .m_sinst_wvalid(m_sinst_wvalid), .m_sinst_wdata(m_sinst_wdata), .m_sinst_wready(m_sinst_wready),
    .m_sinst_decode_finish(m_sinst_decode_finish), .m_sinst_execute_finish(m_sinst_execute_finish),
    .m_sinst_busy(m_sinst_busy),
    .m_sload_tensor_row_wvalid(m_sload_tensor_row_wvalid), .m_sload_tensor_row_wlast(m_sload_tensor_row_wlast),
    .m_sload_tensor_row_wdata(m_sload_tensor_row_wdata), .m_sload_tensor_row_wready(m_sload_tensor_row_wready),
    .m_sstore_tensor_row_rvalid(m_sstore_tensor_row_rvalid), .m_sstore_tensor_row_rlast(m_sstore_tensor_row_rlast),
    .m_sstore_tensor_row_rready(m_sstore_tensor_row_rready), .m_sstore_tensor_row_rdata(m_sstore_tensor_row_rdata),
    .grant_onehot(grant_onehot), .arb_busy(arb_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_inputs();
    r_sinst_wvalid             = '0;
    r_sload_tensor_row_wready  = '0;
    r_sstore_tensor_row_rready = '0;
    m_sinst_wready             = 1'b0;
    m_sinst_decode_finish      = 1'b0;
    m_sinst_execute_finish     = 1'b0;
    m_sinst_busy               = 1'b0;
    m_sload_tensor_row_wvalid  = 1'b0;
    m_sload_tensor_row_wlast   = 1'b0;
    m_sload_tensor_row_wdata   = '0;
    m_sstore_tensor_row_rvalid = 1'b0;
    m_sstore_tensor_row_rlast  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstp = 1'b1;
    tick();
    tick();
    rstp = 1'b0;
  endtask

  // Drives one request through IDLE and an immediate ISSUE handshake; leaves the owner in RUN.
  task automatic issue_one(input logic [N-1:0] req, input logic [N-1:0] exp_grant, input string name);
    r_sinst_wvalid = req;
    m_sinst_wready = 1'b1;
    settle();
    tick();
    settle();
    check(name, 256'(grant_onehot), 256'(exp_grant));
    tick();
    r_sinst_wvalid = '0;
    m_sinst_wready = 1'b0;
  endtask

  task automatic finish_run();
    m_sinst_execute_finish = 1'b1;
    settle();
    tick();
    m_sinst_execute_finish = 1'b0;
  endtask

  function automatic logic [255:0] r_side();
    return 256'({r_sinst_wready, r_sinst_decode_finish, r_sinst_execute_finish, r_sinst_busy,
                 r_sload_tensor_row_wvalid, r_sload_tensor_row_wlast, r_sload_tensor_row_wdata,
                 r_sstore_tensor_row_rvalid, r_sstore_tensor_row_rlast, grant_onehot, arb_busy});
  endfunction

  function automatic logic [255:0] m_side();
    return 256'({m_sinst_wvalid, m_sinst_wdata, m_sload_tensor_row_wready,
                 m_sstore_tensor_row_rready, m_sstore_tensor_row_rdata});
  endfunction

  typedef struct {
    logic [N-1:0]       wv;
    logic               wrdy;
    logic               exe;
    logic [N-1:0]       exp_grant;
    logic               exp_mwv;
    logic [BW_INST-1:0] exp_mdata;
    logic [N-1:0]       exp_rwrdy;
    logic [N-1:0]       exp_rexe;
    logic               exp_arb;
  } vec_t;

  vec_t vecs [8];

  // Reference model: who holds the MLSU, whether its instruction was taken, and the last served index.
  int mdl_holder;
  bit mdl_acc;
  int mdl_last;
  bit mdl_orphan;

  task automatic model_reset();
    mdl_holder = -1;
    mdl_acc    = 1'b0;
    mdl_last   = N - 1;
    mdl_orphan = 1'b0;
  endtask

  task automatic model_check();
    logic [N-1:0]       e_grant, e_wrdy, e_dec, e_exe, e_busy, e_lwv, e_lwl, e_srv, e_srl;
    logic               e_arb, e_mwv, e_lrdy, e_srdy;
    logic [BW_INST-1:0] e_mdata;
    logic [BW_ROW-1:0]  e_ldata, e_srdata;
    e_grant = '0; e_wrdy = '0; e_dec = '0; e_exe = '0; e_busy = '0;
    e_lwv = '0; e_lwl = '0; e_srv = '0; e_srl = '0;
    e_arb = 1'b0; e_mwv = 1'b0; e_lrdy = 1'b0; e_srdy = 1'b0;
    e_mdata = '0; e_ldata = '0; e_srdata = '0;
    if (mdl_holder >= 0) begin
      e_grant[mdl_holder] = 1'b1;
      e_arb               = 1'b1;
      e_dec[mdl_holder]   = m_sinst_decode_finish;
      e_exe[mdl_holder]   = m_sinst_execute_finish;
      if (!mdl_acc) begin
        e_mwv              = r_sinst_wvalid[mdl_holder];
        e_mdata            = r_sinst_wdata[mdl_holder*BW_INST +: BW_INST];
        e_wrdy[mdl_holder] = m_sinst_wready;
      end else begin
        e_busy[mdl_holder] = m_sinst_busy;
        e_lwv[mdl_holder]  = m_sload_tensor_row_wvalid;
        e_lwl[mdl_holder]  = m_sload_tensor_row_wlast;
        e_ldata            = m_sload_tensor_row_wdata;
        e_lrdy             = r_sload_tensor_row_wready[mdl_holder];
        e_srv[mdl_holder]  = m_sstore_tensor_row_rvalid;
        e_srl[mdl_holder]  = m_sstore_tensor_row_rlast;
        e_srdy             = r_sstore_tensor_row_rready[mdl_holder];
        e_srdata           = r_sstore_tensor_row_rdata[mdl_holder*BW_ROW +: BW_ROW];
      end
    end
    check("rand_inst", 256'({m_sinst_wvalid, m_sinst_wdata, r_sinst_wready, grant_onehot, arb_busy}),
          256'({e_mwv, e_mdata, e_wrdy, e_grant, e_arb}));
    check("rand_fin", 256'({r_sinst_decode_finish, r_sinst_execute_finish, r_sinst_busy}),
          256'({e_dec, e_exe, e_busy}));
    check("rand_load", 256'({r_sload_tensor_row_wvalid, r_sload_tensor_row_wlast, r_sload_tensor_row_wdata,
                             m_sload_tensor_row_wready}), 256'({e_lwv, e_lwl, e_ldata, e_lrdy}));
    check("rand_store", 256'({r_sstore_tensor_row_rvalid, r_sstore_tensor_row_rlast, m_sstore_tensor_row_rready,
                              m_sstore_tensor_row_rdata}), 256'({e_srv, e_srl, e_srdy, e_srdata}));
  endtask

  task automatic model_step();
    if (mdl_holder < 0) begin
      mdl_orphan = mdl_orphan | m_sinst_decode_finish | m_sinst_execute_finish;
      for (int j = 1; j <= N; j++) begin
        int c;
        c = (mdl_last + j) % N;
        if (r_sinst_wvalid[c]) begin
          mdl_holder = c;
          mdl_acc    = 1'b0;
          break;
        end
      end
    end else if (!mdl_acc) begin
      if (r_sinst_wvalid[mdl_holder] && m_sinst_wready) begin
        mdl_last = mdl_holder;
        mdl_acc  = 1'b1;
        if (m_sinst_execute_finish) mdl_holder = -1;
      end
    end else if (m_sinst_execute_finish) begin
      mdl_holder = -1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int idle;
    int row;
    int budget;
    logic tog;
    logic [3:0] pat;

    r_sinst_wdata             = {32'hC0DE0002, 32'hC0DE0001, 32'h000000A5};
    r_sstore_tensor_row_rdata = {128'h33, 128'h22, 128'h11};

    // Reset: outputs stay zero even with MLSU-side activity present.
    do_reset();
    rstp = 1'b1;
    m_sload_tensor_row_wvalid  = 1'b1;
    m_sstore_tensor_row_rvalid = 1'b1;
    m_sinst_busy               = 1'b1;
    r_sload_tensor_row_wready  = '1;
    r_sstore_tensor_row_rready = '1;
    settle();
    check("reset_r_side", r_side(), 256'(0));
    check("reset_m_side", m_side(), 256'(0));
    tick();
    rstp = 1'b0;
    clear_inputs();

    // Single request from r0 with a 2-cycle wready delay, then an orphan pulse in IDLE.
    vecs[0] = '{3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0};
    vecs[1] = '{3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 32'hA5, 3'b000, 3'b000, 1'b1};
    vecs[2] = '{3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 32'hA5, 3'b000, 3'b000, 1'b1};
    vecs[3] = '{3'b001, 1'b1, 1'b0, 3'b001, 1'b1, 32'hA5, 3'b001, 3'b000, 1'b1};
    vecs[4] = '{3'b000, 1'b0, 1'b0, 3'b001, 1'b0, 32'h0,  3'b000, 3'b000, 1'b1};
    vecs[5] = '{3'b000, 1'b0, 1'b1, 3'b001, 1'b0, 32'h0,  3'b000, 3'b001, 1'b1};
    vecs[6] = '{3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0};
    vecs[7] = '{3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0,  3'b000, 3'b000, 1'b0};
    for (int i = 0; i < 8; i++) begin
      r_sinst_wvalid         = vecs[i].wv;
      m_sinst_wready         = vecs[i].wrdy;
      m_sinst_execute_finish = vecs[i].exe;
      settle();
      check($sformatf("vec%0d_grant", i), 256'(grant_onehot), 256'(vecs[i].exp_grant));
      check($sformatf("vec%0d_inst", i), 256'({m_sinst_wvalid, m_sinst_wdata}),
            256'({vecs[i].exp_mwv, vecs[i].exp_mdata}));
      check($sformatf("vec%0d_ack", i), 256'({r_sinst_wready, r_sinst_execute_finish, arb_busy}),
            256'({vecs[i].exp_rwrdy, vecs[i].exp_rexe, vecs[i].exp_arb}));
      tick();
    end
    clear_inputs();
    check("orphan_flag", 256'(dut.err_orphan), 256'(1'b1));

    // Contention: r0 and r1 always valid, alternate with one idle cycle between grants.
    do_reset();
    r_sinst_wvalid = 3'b011;
    m_sinst_wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle = 0;
      settle();
      while (grant_onehot == '0 && idle < 8) begin
        idle++;
        tick();
        settle();
      end
      check($sformatf("cont_grant%0d", k), 256'(grant_onehot), 256'((k % 2 == 0) ? 3'b001 : 3'b010));
      check($sformatf("cont_gap%0d", k), 256'(idle), 256'(1));
      tick();
      finish_run();
    end
    clear_inputs();

    // Load rows to r1 with r1's ready toggling; r0 is always ready but must never see a row.
    issue_one(3'b010, 3'b010, "load_grant");
    row = 0; budget = 0; tog = 1'b1;
    while (row < 4 && budget < 20) begin
      m_sload_tensor_row_wvalid = 1'b1;
      m_sload_tensor_row_wdata  = BW_ROW'(row);
      m_sload_tensor_row_wlast  = (row == 3);
      r_sload_tensor_row_wready = {1'b0, tog, 1'b1};
      settle();
      check("load_valid", 256'(r_sload_tensor_row_wvalid), 256'(3'b010));
      check("load_last", 256'(r_sload_tensor_row_wlast), 256'((row == 3) ? 3'b010 : 3'b000));
      check("load_data", 256'(r_sload_tensor_row_wdata), 256'(row));
      check("load_ready", 256'(m_sload_tensor_row_wready), 256'(tog));
      if (tog) row++;
      tick();
      budget++;
      tog = ~tog;
    end
    check("load_beats", 256'(row), 256'(4));
    clear_inputs();
    finish_run();

    // Store rows from r0: data and ready come from slice 0 only.
    issue_one(3'b001, 3'b001, "store_grant");
    pat = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      m_sstore_tensor_row_rvalid = 1'b1;
      m_sstore_tensor_row_rlast  = (k == 3);
      r_sstore_tensor_row_rready = {1'b1, ~pat[k], pat[k]};
      settle();
      check("store_data", 256'(m_sstore_tensor_row_rdata), 256'(8'h11));
      check("store_ready", 256'(m_sstore_tensor_row_rready), 256'(pat[k]));
      check("store_valid", 256'({r_sstore_tensor_row_rvalid, r_sstore_tensor_row_rlast}),
            256'({3'b001, (k == 3) ? 3'b001 : 3'b000}));
      tick();
    end
    clear_inputs();
    finish_run();

    // Handshake and execute_finish in the same cycle.
    r_sinst_wvalid = 3'b100;
    m_sinst_wready = 1'b1;
    settle();
    tick();
    m_sinst_execute_finish = 1'b1;
    settle();
    check("co_ack", 256'({r_sinst_wready, r_sinst_execute_finish}), 256'({3'b100, 3'b100}));
    tick();
    clear_inputs();
    settle();
    check("co_idle", 256'({grant_onehot, arb_busy}), 256'(0));
    tick();

    // Reset while r1 is in RUN: everything drops and r0 is served first afterwards.
    issue_one(3'b010, 3'b010, "rst_grant");
    m_sinst_busy               = 1'b1;
    m_sload_tensor_row_wvalid  = 1'b1;
    m_sstore_tensor_row_rvalid = 1'b1;
    r_sload_tensor_row_wready  = '1;
    r_sstore_tensor_row_rready = '1;
    settle();
    check("rst_pre_busy", 256'(r_sinst_busy), 256'(3'b010));
    rstp = 1'b1;
    tick();
    rstp = 1'b0;
    settle();
    check("rst_r_side", r_side(), 256'(0));
    check("rst_m_side", m_side(), 256'(0));
    tick();
    clear_inputs();
    r_sinst_wvalid = 3'b011;
    settle();
    tick();
    settle();
    check("rst_next_owner", 256'(grant_onehot), 256'(3'b001));
    clear_inputs();

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      r_sinst_wvalid             = N'($urandom);
      r_sinst_wdata              = {$urandom, $urandom, $urandom};
      m_sinst_wready             = ($urandom_range(0, 1) == 1);
      m_sinst_decode_finish      = ($urandom_range(0, 4) == 0);
      m_sinst_execute_finish     = ($urandom_range(0, 3) == 0);
      m_sinst_busy               = ($urandom_range(0, 1) == 1);
      m_sload_tensor_row_wvalid  = ($urandom_range(0, 1) == 1);
      m_sload_tensor_row_wlast   = ($urandom_range(0, 3) == 0);
      m_sload_tensor_row_wdata   = {$urandom, $urandom, $urandom, $urandom};
      r_sload_tensor_row_wready  = N'($urandom);
      m_sstore_tensor_row_rvalid = ($urandom_range(0, 1) == 1);
      m_sstore_tensor_row_rlast  = ($urandom_range(0, 3) == 0);
      r_sstore_tensor_row_rready = N'($urandom);
      r_sstore_tensor_row_rdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      settle();
      model_check();
      model_step();
      tick();
    end
    clear_inputs();
    settle();
    check("rand_orphan", 256'(dut.err_orphan), 256'(mdl_orphan));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
